// File: rtl/inta_sequencer.sv
// 8259A-style INT/INTA sequencer: owns the ISR, runs the two-pulse 8086 INTA handshake and EOI.
// Optional feature: define INTA_TIMEOUT_EN to abort a stalled handshake after TIMEOUT_CYCLES in WAIT2.
module inta_sequencer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pr_valid,
  input  logic [2:0] pr_level,
  input  logic       inta_n,
  input  logic [4:0] vec_base,
  input  logic       aeoi,
  input  logic       eoi_ns,
  input  logic       eoi_sp,
  input  logic [2:0] eoi_level,
  output logic       int_out,
  output logic [7:0] irr_clr,
  output logic [7:0] isr,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       timeout
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] ACK1  = 3'd2;
  localparam logic [2:0] WAIT2 = 3'd3;
  localparam logic [2:0] ACK2  = 3'd4;

  logic [2:0] state_reg;
  logic       inta_q;
  logic [2:0] lvl_reg;
  logic       spurious_reg;
  logic       inta_fall;
  logic       inta_rise;
  logic       timeout_hit;
  logic [7:0] low_set;
  logic [7:0] eoi_mask;
  logic [7:0] isr_set;
  logic [7:0] hs_clr;
  logic [7:0] isr_next;

  assign inta_fall = inta_q & ~inta_n;
  assign inta_rise = ~inta_q & inta_n;

  // One-hot of the lowest-index (highest-priority) in-service bit, for non-specific EOI.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_low
      if (gi == 0) begin : g_first
        assign low_set[gi] = isr[gi];
      end else begin : g_rest
        assign low_set[gi] = isr[gi] & ~(|isr[gi-1:0]);
      end
    end
  endgenerate

  always_comb begin
    eoi_mask = 8'h00;
    isr_set  = 8'h00;
    hs_clr   = 8'h00;
    if (eoi_sp)
      eoi_mask = 8'b1 << eoi_level;
    else if (eoi_ns)
      eoi_mask = low_set;
    if (state_reg == REQ && inta_fall && pr_valid)
      isr_set = 8'b1 << pr_level;
    if (state_reg == ACK2 && inta_rise && aeoi && !spurious_reg)
      hs_clr = 8'b1 << lvl_reg;
    if (timeout_hit && !spurious_reg)
      hs_clr = 8'b1 << lvl_reg;
    // Clears act on the pre-edge ISR; a same-cycle set wins.
    isr_next = (isr & ~eoi_mask & ~hs_clr) | isr_set;
  end

`ifdef INTA_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt_reg;
  logic          timeout_reg;

  assign timeout_hit = (state_reg == WAIT2) && !inta_fall && (to_cnt_reg == CW'(TIMEOUT_CYCLES));
  assign timeout     = timeout_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= timeout_hit;
      if (state_reg != WAIT2 || timeout_hit)
        to_cnt_reg <= '0;
      else
        to_cnt_reg <= to_cnt_reg + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign timeout_hit        = 1'b0;
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      inta_q       <= 1'b1;
      lvl_reg      <= 3'd0;
      spurious_reg <= 1'b0;
      int_out      <= 1'b0;
      irr_clr      <= 8'h00;
      isr          <= 8'h00;
      data_out     <= 8'h00;
      data_oe      <= 1'b0;
    end else begin
      inta_q  <= inta_n;
      irr_clr <= 8'h00;
      isr     <= isr_next;
      case (state_reg)
        IDLE: begin
          if (pr_valid) begin
            int_out   <= 1'b1;
            state_reg <= REQ;
          end
        end
        REQ: begin
          if (inta_fall) begin
            // A request that vanished before INTA is answered with the level-7 spurious vector.
            lvl_reg      <= pr_valid ? pr_level : 3'd7;
            spurious_reg <= ~pr_valid;
            if (pr_valid)
              irr_clr <= 8'b1 << pr_level;
            int_out   <= 1'b0;
            state_reg <= ACK1;
          end
        end
        ACK1: begin
          if (inta_rise)
            state_reg <= WAIT2;
        end
        WAIT2: begin
          if (inta_fall) begin
            data_oe   <= 1'b1;
            data_out  <= {vec_base, lvl_reg};
            state_reg <= ACK2;
          end else if (timeout_hit) begin
            state_reg <= IDLE;
          end
        end
        ACK2: begin
          if (inta_rise) begin
            data_oe   <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed self-checking bench for inta_sequencer; timeout scenario adapts to INTA_TIMEOUT_EN.
module tb_inta_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pr_valid;
  logic [2:0] pr_level;
  logic       inta_n;
  logic [4:0] vec_base;
  logic       aeoi;
  logic       eoi_ns;
  logic       eoi_sp;
  logic [2:0] eoi_level;
  logic       int_out;
  logic [7:0] irr_clr;
  logic [7:0] isr;
  logic [7:0] data_out;
  logic       data_oe;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  inta_sequencer #(.TIMEOUT_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pr_valid  (pr_valid),
    .pr_level  (pr_level),
    .inta_n    (inta_n),
    .vec_base  (vec_base),
    .aeoi      (aeoi),
    .eoi_ns    (eoi_ns),
    .eoi_sp    (eoi_sp),
    .eoi_level (eoi_level),
    .int_out   (int_out),
    .irr_clr   (irr_clr),
    .isr       (isr),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .timeout   (timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input string tag, input logic [2:0] lv);
    pr_level = lv;
    pr_valid = 1'b1;
    check({tag, "_int_pre"}, int_out, 0);
    tick();
    check({tag, "_int"}, int_out, 1);
  endtask

  task automatic run_ack(input string tag, input logic [7:0] exp_isr_grant, input logic [7:0] exp_irr,
                         input logic [7:0] exp_vec, input logic [7:0] exp_isr_end, input bit sp_at_grant);
    eoi_sp = sp_at_grant;
    inta_n = 1'b0;
    tick();
    eoi_sp   = 1'b0;
    pr_valid = 1'b0;
    check({tag, "_isr_grant"}, isr, exp_isr_grant);
    check({tag, "_irr_clr"}, irr_clr, exp_irr);
    check({tag, "_int_low"}, int_out, 0);
    tick();
    check({tag, "_irr_pulse"}, irr_clr, 0);
    inta_n = 1'b1;
    tick();
    tick();
    check({tag, "_oe_wait"}, data_oe, 0);
    inta_n = 1'b0;
    tick();
    check({tag, "_oe"}, data_oe, 1);
    check({tag, "_vec"}, data_out, exp_vec);
    tick();
    check({tag, "_vec_hold"}, data_out, exp_vec);
    inta_n = 1'b1;
    tick();
    check({tag, "_oe_off"}, data_oe, 0);
    check({tag, "_isr_end"}, isr, exp_isr_end);
    $display("txn %s: vec=%02h isr=%02h", tag, exp_vec, isr);
  endtask

  task automatic eoi_specific(input string tag, input logic [2:0] lv, input logic [7:0] exp_isr);
    eoi_level = lv;
    eoi_sp    = 1'b1;
    tick();
    eoi_sp = 1'b0;
    check(tag, isr, exp_isr);
    $display("txn %s: eoi_sp level %0d isr=%02h", tag, lv, isr);
  endtask

  initial begin
    int seen_at;
    rst_n = 1'b0; pr_valid = 1'b0; pr_level = 3'd0; inta_n = 1'b1;
    vec_base = 5'h08; aeoi = 1'b0; eoi_ns = 1'b0; eoi_sp = 1'b0; eoi_level = 3'd0;
    tick();
    tick();
    check("rst_int", int_out, 0);
    check("rst_irr", irr_clr, 0);
    check("rst_isr", isr, 0);
    check("rst_dout", data_out, 0);
    check("rst_oe", data_oe, 0);
    check("rst_to", timeout, 0);
    rst_n = 1'b1;
    tick();
    $display("txn reset: outputs idle");

    // Normal grant, then a second level stacked in service.
    request("norm", 3'd3);
    run_ack("norm", 8'h08, 8'h08, 8'h43, 8'h08, 1'b0);
    request("second", 3'd1);
    run_ack("second", 8'h0A, 8'h02, 8'h41, 8'h0A, 1'b0);

    eoi_ns = 1'b1;
    tick();
    eoi_ns = 1'b0;
    check("eoi_ns", isr, 8'h08);
    $display("txn eoi_ns: isr=%02h", isr);
    eoi_specific("eoi_sp", 3'd3, 8'h00);

    eoi_ns = 1'b1;
    tick();
    eoi_ns = 1'b0;
    check("eoi_ns_empty", isr, 8'h00);

    aeoi = 1'b1;
    request("aeoi", 3'd3);
    run_ack("aeoi", 8'h08, 8'h08, 8'h43, 8'h00, 1'b0);
    aeoi = 1'b0;

    // Request withdrawn before INTA: spurious level 7.
    vec_base = 5'h11;
    request("spur", 3'd5);
    pr_valid = 1'b0;
    tick();
    check("spur_int_hold", int_out, 1);
    run_ack("spur", 8'h00, 8'h00, 8'h8F, 8'h00, 1'b0);

    // Specific EOI on level 3 coincident with the level-3 grant: the set wins.
    vec_base  = 5'h08;
    eoi_level = 3'd3;
    request("simul", 3'd3);
    run_ack("simul", 8'h08, 8'h08, 8'h43, 8'h08, 1'b1);
    eoi_specific("simul_clr", 3'd3, 8'h00);

    // Asynchronous reset while waiting for the second INTA.
    request("rstmid", 3'd5);
    inta_n = 1'b0;
    tick();
    pr_valid = 1'b0;
    check("rstmid_isr", isr, 8'h20);
    tick();
    inta_n = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    check("rstmid_int", int_out, 0);
    check("rstmid_irr", irr_clr, 0);
    check("rstmid_isr0", isr, 0);
    check("rstmid_dout", data_out, 0);
    check("rstmid_oe", data_oe, 0);
    check("rstmid_to", timeout, 0);
    $display("txn rstmid: outputs cleared");
    tick();
    rst_n = 1'b1;
    tick();
    request("afterrst", 3'd2);
    run_ack("afterrst", 8'h04, 8'h04, 8'h42, 8'h04, 1'b0);
    eoi_specific("afterrst_clr", 3'd2, 8'h00);

    // Stall in WAIT2 with no second INTA.
    request("stall", 3'd6);
    inta_n = 1'b0;
    tick();
    pr_valid = 1'b0;
    check("stall_isr", isr, 8'h40);
    tick();
    inta_n = 1'b1;
    tick();
    seen_at = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (timeout === 1'b1) begin
        seen_at = n;
        break;
      end
    end
`ifdef INTA_TIMEOUT_EN
    check("to_seen", 32'(seen_at >= 4 && seen_at <= 6), 1);
    check("to_isr", isr, 8'h00);
    tick();
    check("to_pulse", timeout, 0);
    $display("txn timeout: fired after %0d cycles", seen_at);
    request("postto", 3'd0);
    run_ack("postto", 8'h01, 8'h01, 8'h40, 8'h01, 1'b0);
    eoi_specific("postto_clr", 3'd0, 8'h00);
`else
    check("no_to", seen_at, 0);
    check("stall_oe", data_oe, 0);
    inta_n = 1'b0;
    tick();
    check("stall_oe_late", data_oe, 1);
    check("stall_vec", data_out, 8'h46);
    inta_n = 1'b1;
    tick();
    check("stall_isr_end", isr, 8'h40);
    $display("txn stall: late second INTA vec=%02h", data_out);
    eoi_specific("stall_clr", 3'd6, 8'h00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
